// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with registered occupancy level, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_LVL_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_lvl #(
  parameter int unsigned W      = 4,
  parameter int unsigned B      = 16,
  parameter int unsigned AF_THR = 12,
  parameter int unsigned AE_THR = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enRd,
  input  logic         enWr,
  input  logic [B-1:0] dataW,
  output logic [B-1:0] dataR,
  output logic         emptyR,
  output logic         fullW,
  output logic         almostEmpty,
  output logic         almostFull,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned DEPTH = 1 << W;
  localparam int unsigned LW    = W + 1;

  logic [B-1:0]  mem_q [DEPTH];
  logic [W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  // Acceptance is decided from the registered flags, so a full FIFO never takes a write
  // in the same cycle it frees a slot (and likewise for reads when empty).
  always_comb begin
    wr_acc   = enWr & ~full_q;
    rd_acc   = enRd & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (enWr && full_q && !rd_acc) ovf_d = 1'b1;
    if (enRd && empty_q)           udf_d = 1'b1;
    // Flags derive from the next level so they change on the same edge as level.
    empty_d = (level_d == LW'(0));
    full_d  = (level_d == LW'(DEPTH));
    ae_d    = (level_d <= LW'(AE_THR));
    af_d    = (level_d >= LW'(AF_THR));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not cleared by reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= dataW;
  end

`ifdef SYNC_FIFO_LVL_FWFT_EN
  assign dataR = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  logic [B-1:0] data_r_q, data_r_d;

  always_comb begin
    data_r_d = data_r_q;
    if (rd_acc) data_r_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) data_r_q <= '0;
    else     data_r_q <= data_r_d;
  end

  assign dataR = data_r_q;
`endif

  assign level       = level_q;
  assign emptyR      = empty_q;
  assign fullW       = full_q;
  assign almostEmpty = ae_q;
  assign almostFull  = af_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Self-checking bench for sync_fifo_lvl: queue-based reference model plus directed literal checks.
module tb_sync_fifo_lvl;

  localparam int W      = 4;
  localparam int B      = 16;
  localparam int DEPTH  = 16;
  localparam int AF_THR = 12;
  localparam int AE_THR = 3;

  logic         clk = 1'b0;
  logic         rst, enRd, enWr;
  logic [B-1:0] dataW, dataR;
  logic         emptyR, fullW, almostEmpty, almostFull, overflow, underflow;
  logic [W:0]   level;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [B-1:0] q[$];
  logic [B-1:0] m_dr;
  bit           m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_lvl #(.W(W), .B(B), .AF_THR(AF_THR), .AE_THR(AE_THR)) dut (
    .clk(clk), .rst(rst), .enRd(enRd), .enWr(enWr), .dataW(dataW), .dataR(dataR),
    .emptyR(emptyR), .fullW(fullW), .almostEmpty(almostEmpty), .almostFull(almostFull),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, with the FIFO rules applied to its size.
  always @(posedge clk) begin
    bit full, empty;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_dr  = '0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (enRd && empty)          m_udf = 1'b1;
      if (enWr && full && !enRd)  m_ovf = 1'b1;
      if (enRd && !empty)         m_dr = q.pop_front();
      if (enWr && !full)          q.push_back(dataW);
    end
  end

  function automatic logic [B-1:0] exp_dr();
`ifdef SYNC_FIFO_LVL_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dr;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_level",  32'(level),       32'(q.size()));
      chk("cyc_empty",  32'(emptyR),      32'(q.size() == 0));
      chk("cyc_full",   32'(fullW),       32'(q.size() == DEPTH));
      chk("cyc_ae",     32'(almostEmpty), 32'(q.size() <= AE_THR));
      chk("cyc_af",     32'(almostFull),  32'(q.size() >= AF_THR));
      chk("cyc_ovf",    32'(overflow),    32'(m_ovf));
      chk("cyc_udf",    32'(underflow),   32'(m_udf));
      chk("cyc_dataR",  32'(dataR),       32'(exp_dr()));
    end
  end

  task automatic step(input logic r, input logic rd, input logic wr, input logic [B-1:0] d);
    rst   = r;
    enRd  = rd;
    enWr  = wr;
    dataW = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [B-1:0] e;
    rst = 1'b1; enRd = 1'b0; enWr = 1'b0; dataW = '0;
    step(1'b1, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(emptyR), 1);
    chk("rst_full",  32'(fullW), 0);
    chk("rst_ae",    32'(almostEmpty), 1);
    chk("rst_af",    32'(almostFull), 0);
    chk("rst_dataR", 32'(dataR), 0);

    // Fill 0x0000..0x000F, checking threshold crossings.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'(i));
      chk("fill_level", 32'(level), 32'(i + 1));
      if (i + 1 == 3)  chk("ae_at3",  32'(almostEmpty), 1);
      if (i + 1 == 4)  chk("ae_at4",  32'(almostEmpty), 0);
      if (i + 1 == 11) chk("af_at11", 32'(almostFull), 0);
      if (i + 1 == 12) chk("af_at12", 32'(almostFull), 1);
    end
    chk("full_at16", 32'(fullW), 1);

    step(1'b0, 1'b0, 1'b1, 16'hCAFE);
    chk("ovf_set",   32'(overflow), 1);
    chk("ovf_level", 32'(level), 16);

    // Drain in order; CAFE must not appear.
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 1'b0, '0);
`ifdef SYNC_FIFO_LVL_FWFT_EN
      e = (k < 15) ? 16'(k + 1) : 16'h0000;
`else
      e = 16'(k);
`endif
      chk("drain_data", 32'(dataR), 32'(e));
    end
    chk("drain_empty", 32'(emptyR), 1);
    chk("drain_udf",   32'(underflow), 0);

    step(1'b0, 1'b1, 1'b0, '0);
    chk("udf_set",   32'(underflow), 1);
    chk("udf_level", 32'(level), 0);
`ifdef SYNC_FIFO_LVL_FWFT_EN
    chk("udf_dataR", 32'(dataR), 32'h0000);
`else
    chk("udf_dataR", 32'(dataR), 32'h000F);
`endif

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 16'(16'h0100 + i));
    chk("lvl8", 32'(level), 8);

    // Steady state at level 8: pointers wrap twice over 40 cycles.
    for (int j = 0; j < 40; j++) begin
      step(1'b0, 1'b1, 1'b1, 16'(16'h0200 + j));
      chk("ss_level", 32'(level), 8);
`ifdef SYNC_FIFO_LVL_FWFT_EN
      e = (j + 1 < 8) ? 16'(16'h0100 + j + 1) : 16'(16'h0200 + j + 1 - 8);
`else
      e = (j < 8) ? 16'(16'h0100 + j) : 16'(16'h0200 + j - 8);
`endif
      chk("ss_data", 32'(dataR), 32'(e));
    end

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 16'(16'h0300 + i));
    chk("refill_full", 32'(fullW), 1);
    step(1'b0, 1'b1, 1'b1, 16'h03AA);
    chk("full_rw_level", 32'(level), 15);
    chk("full_rw_full",  32'(fullW), 0);

    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("empty_again", 32'(emptyR), 1);
    step(1'b0, 1'b1, 1'b1, 16'h0444);
    chk("empty_rw_level", 32'(level), 1);
    chk("empty_rw_empty", 32'(emptyR), 0);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 16'(16'h0500 + i));
    chk("lvl5", 32'(level), 5);

    // Reset wins over simultaneous requests.
    step(1'b1, 1'b1, 1'b1, 16'hDEAD);
    chk("mrst_level", 32'(level), 0);
    chk("mrst_empty", 32'(emptyR), 1);
    chk("mrst_ae",    32'(almostEmpty), 1);
    chk("mrst_af",    32'(almostFull), 0);
    chk("mrst_ovf",   32'(overflow), 0);
    chk("mrst_udf",   32'(underflow), 0);
    chk("mrst_dataR", 32'(dataR), 0);

    step(1'b0, 1'b0, 1'b1, 16'hBEEF);
`ifdef SYNC_FIFO_LVL_FWFT_EN
    chk("post_rst_head", 32'(dataR), 32'hBEEF);
`else
    chk("post_rst_hold", 32'(dataR), 0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("post_rst_read", 32'(dataR), 32'hBEEF);
`endif
    step(1'b0, 1'b0, 1'b0, '0);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
